// File: rtl/regfile.sv
// Three-port combinational-read register file with one-hot write enables and write-through reads.
// Define REGFILE_R0_ZERO_EN to hardwire register 0 to zero.
module regfile #(
  parameter int unsigned W_DATA = 32,
  parameter int unsigned W_ADDR = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [W_DATA-1:0]      cdb_wdata,
  input  logic [2**W_ADDR-1:0]   rst_wen_onehot,
  input  logic [W_ADDR-1:0]      dispatch_rsaddr,
  input  logic [W_ADDR-1:0]      dispatch_rtaddr,
  input  logic [W_ADDR-1:0]      debug_addr,
  output logic [W_DATA-1:0]      dispatch_rsdata,
  output logic [W_DATA-1:0]      dispatch_rtdata,
  output logic [W_DATA-1:0]      debug_data
);

  localparam int unsigned N = 2 ** W_ADDR;

`ifdef REGFILE_R0_ZERO_EN
  localparam int unsigned FirstWr = 1;
`else
  localparam int unsigned FirstWr = 0;
`endif

  logic [W_DATA-1:0] mem_q [N];

  // Register 0 is reset but never written when it is hardwired.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(N); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = int'(FirstWr); i < int'(N); i++) begin
        if (rst_wen_onehot[i]) begin
          mem_q[i] <= cdb_wdata;
        end
      end
    end
  end

  logic [W_ADDR-1:0] raddr [3];
  logic [W_DATA-1:0] rdata [3];

  assign raddr[0] = dispatch_rsaddr;
  assign raddr[1] = dispatch_rtaddr;
  assign raddr[2] = debug_addr;

  for (genvar p = 0; p < 3; p++) begin : g_rd
    always_comb begin
      rdata[p] = mem_q[raddr[p]];
      if (rst_wen_onehot[raddr[p]]) begin
        rdata[p] = cdb_wdata;
      end
`ifdef REGFILE_R0_ZERO_EN
      if (raddr[p] == '0) begin
        rdata[p] = '0;
      end
`endif
      // Reset forces zero even over the write-through path.
      if (!reset) begin
        rdata[p] = '0;
      end
    end
  end

  assign dispatch_rsdata = rdata[0];
  assign dispatch_rtdata = rdata[1];
  assign debug_data      = rdata[2];

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: write-all, no-write, write-through, multi-hot, reset.
module tb_regfile;

  localparam int unsigned W_DATA = 32;
  localparam int unsigned W_ADDR = 5;
  localparam int unsigned N      = 32;

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0Zero = 1'b1;
`else
  localparam bit R0Zero = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [W_DATA-1:0] cdb_wdata;
  logic [N-1:0]      rst_wen_onehot;
  logic [W_ADDR-1:0] dispatch_rsaddr;
  logic [W_ADDR-1:0] dispatch_rtaddr;
  logic [W_ADDR-1:0] debug_addr;
  logic [W_DATA-1:0] dispatch_rsdata;
  logic [W_DATA-1:0] dispatch_rtdata;
  logic [W_DATA-1:0] debug_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [W_DATA-1:0] model [N];

  regfile #(
    .W_DATA(W_DATA),
    .W_ADDR(W_ADDR)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cdb_wdata      (cdb_wdata),
    .rst_wen_onehot (rst_wen_onehot),
    .dispatch_rsaddr(dispatch_rsaddr),
    .dispatch_rtaddr(dispatch_rtaddr),
    .debug_addr     (debug_addr),
    .dispatch_rsdata(dispatch_rsdata),
    .dispatch_rtdata(dispatch_rtdata),
    .debug_data     (debug_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W_DATA-1:0] obs, input logic [W_DATA-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W_DATA-1:0] expv(input int a);
    if (R0Zero && a == 0) return '0;
    return model[a];
  endfunction

  // Apply the current write vector to the model after a clock edge.
  task automatic model_write();
    for (int i = 0; i < int'(N); i++) begin
      if (rst_wen_onehot[i] && !(R0Zero && i == 0)) model[i] = cdb_wdata;
    end
  endtask

  // rs sweeps up, rt sweeps down, debug tracks rs.
  task automatic sweep(input string tag);
    for (int a = 0; a < int'(N); a++) begin
      dispatch_rsaddr = W_ADDR'(a);
      dispatch_rtaddr = W_ADDR'(N - 1 - a);
      debug_addr      = W_ADDR'(a);
      #1;
      chk($sformatf("%s_rs[%0d]", tag, a), dispatch_rsdata, expv(a));
      chk($sformatf("%s_rt[%0d]", tag, N - 1 - a), dispatch_rtdata, expv(int'(N) - 1 - a));
      chk($sformatf("%s_dbg[%0d]", tag, a), debug_data, expv(a));
    end
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) model[i] = '0;
    reset           = 1'b0;
    cdb_wdata       = '0;
    rst_wen_onehot  = '0;
    dispatch_rsaddr = '0;
    dispatch_rtaddr = 5'd1;
    debug_addr      = 5'd2;
    #12;
    chk("rst_rs", dispatch_rsdata, '0);
    chk("rst_rt", dispatch_rtdata, '0);
    chk("rst_dbg", debug_data, '0);

    // Write-through suppressed while in reset, and the write is not captured.
    rst_wen_onehot  = '1;
    cdb_wdata       = 32'hFFFF_FFFF;
    dispatch_rsaddr = 5'd3;
    #1;
    chk("rst_wt_rs", dispatch_rsdata, '0);
    tick();
    rst_wen_onehot = '0;
    reset          = 1'b1;
    #1;
    chk("rst_nowrite_r3", dispatch_rsdata, '0);

    // Write-all with write-through check before each edge.
    for (int i = 0; i < int'(N); i++) begin
      rst_wen_onehot  = N'(1) << i;
      cdb_wdata       = W_DATA'(i + 1);
      dispatch_rsaddr = W_ADDR'(i);
      #1;
      chk($sformatf("wall_wt[%0d]", i), dispatch_rsdata,
          (R0Zero && i == 0) ? '0 : W_DATA'(i + 1));
      @(posedge clk);
      model_write();
      #1;
    end
    rst_wen_onehot = '0;
    sweep("wall");

    // No-write hold.
    cdb_wdata = 32'hDEAD_BEEF;
    repeat (4) tick();
    debug_addr = 5'd7;
    #1;
    chk("nowr_r7", debug_data, 32'd8);
    sweep("nowr");

    // Write-through on rs while debug reads a neighbour.
    dispatch_rsaddr = 5'd5;
    debug_addr      = 5'd6;
    rst_wen_onehot  = N'(1) << 5;
    cdb_wdata       = 32'h1234_5678;
    #1;
    chk("wt_pre_rs5", dispatch_rsdata, 32'h1234_5678);
    chk("wt_dbg6", debug_data, 32'd7);
    @(posedge clk);
    model_write();
    #1;
    rst_wen_onehot = '0;
    cdb_wdata      = '0;
    #1;
    chk("wt_post_rs5", dispatch_rsdata, 32'h1234_5678);

    // Multi-hot write of registers 8 and 9.
    rst_wen_onehot  = 32'h0000_0300;
    cdb_wdata       = 32'hA5A5_A5A5;
    dispatch_rtaddr = 5'd9;
    debug_addr      = 5'd10;
    #1;
    chk("mh_wt_rt9", dispatch_rtdata, 32'hA5A5_A5A5);
    chk("mh_wt_dbg10", debug_data, 32'd11);
    @(posedge clk);
    model_write();
    #1;
    rst_wen_onehot  = '0;
    dispatch_rsaddr = 5'd8;
    #1;
    chk("mh_r8", dispatch_rsdata, 32'hA5A5_A5A5);
    chk("mh_r9", dispatch_rtdata, 32'hA5A5_A5A5);
    chk("mh_r10", debug_data, 32'd11);
    sweep("mh");

    // Asynchronous reset mid-cycle with a pending write.
    dispatch_rsaddr = 5'd5;
    dispatch_rtaddr = 5'd9;
    debug_addr      = 5'd31;
    rst_wen_onehot  = N'(1) << 4;
    cdb_wdata       = 32'h0BAD_F00D;
    #1;
    reset = 1'b0;
    #1;
    chk("arst_rs", dispatch_rsdata, '0);
    chk("arst_rt", dispatch_rtdata, '0);
    chk("arst_dbg", debug_data, '0);
    for (int i = 0; i < int'(N); i++) model[i] = '0;
    tick();
    rst_wen_onehot = '0;
    #2;
    reset = 1'b1;
    #1;
    sweep("post_rst");

    // First write after release lands on the first edge.
    rst_wen_onehot  = N'(1) << 3;
    cdb_wdata       = 32'h0000_0077;
    @(posedge clk);
    model_write();
    #1;
    rst_wen_onehot  = '0;
    dispatch_rsaddr = 5'd3;
    dispatch_rtaddr = 5'd4;
    #1;
    chk("rel_r3", dispatch_rsdata, 32'h0000_0077);
    chk("rel_r4", dispatch_rtdata, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter W_DATA SHALL default to 32 and set the data width.
REQ-002 Parameter W_ADDR SHALL default to 5 and set the address width; the register count is N = 2**W_ADDR (32).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all writes occur on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port cdb_wdata, input, W_DATA bits, SHALL carry the write data from the common data bus.
REQ-006 Port rst_wen_onehot, input, N bits, SHALL carry the write-enable vector from the register status table; bit i selects register i.
REQ-007 Port dispatch_rsaddr, input, W_ADDR bits, SHALL be the RS read address.
REQ-008 Port dispatch_rtaddr, input, W_ADDR bits, SHALL be the RT read address.
REQ-009 Port debug_addr, input, W_ADDR bits, SHALL be the debug read address.
REQ-010 Port dispatch_rsdata, output, W_DATA bits, SHALL be the RS read data.
REQ-011 Port dispatch_rtdata, output, W_DATA bits, SHALL be the RT read data.
REQ-012 Port debug_data, output, W_DATA bits, SHALL be the debug read data.

Function
REQ-013 Storage SHALL be N registers of W_DATA bits each.
REQ-014 On each rising clk edge with reset deasserted, every register i whose bit rst_wen_onehot[i] is 1 SHALL load cdb_wdata.
REQ-015 An all-zero rst_wen_onehot SHALL leave every register unchanged.
REQ-016 A vector with several bits set SHALL write cdb_wdata to every selected register; this is legal and not an error.
REQ-017 All three read ports SHALL be combinational: data is valid in the same cycle as the address, with zero-cycle latency and no handshake.
REQ-018 Each read port SHALL be write-through: if rst_wen_onehot selects the addressed register in the current cycle, the port SHALL output cdb_wdata instead of the stored value.
REQ-019 The three read ports SHALL be independent; identical addresses on several ports SHALL return identical data.
REQ-020 Simultaneous reads and writes to any combination of registers SHALL carry no restriction.
REQ-021 Addresses SHALL use the full W_ADDR range with no out-of-range case.

Reset
REQ-022 When reset is 0, all registers SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-023 While reset is asserted, writes SHALL be ignored and every read port SHALL output 0, including when write-through would otherwise apply.
REQ-024 Reset asserted in the middle of a write sequence SHALL discard the pending write; the first write after release SHALL occur on the first rising edge with reset equal to 1.

Configuration
REQ-025 The macro REGFILE_R0_ZERO_EN SHALL control register 0 as follows:
- Defined: register 0 is hardwired to 0, writes to it are ignored, and reads of address 0 (including write-through) return 0.
- Undefined: register 0 is an ordinary writable register.

Verification
REQ-026 Write-all scenario: release reset, then for i = 0..31 drive rst_wen_onehot = 1<<i and cdb_wdata = i+1 for one cycle each; then sweep dispatch_rsaddr, dispatch_rtaddr and debug_addr over 0..31.
- Required: each port returns i+1 for address i.
- With REGFILE_R0_ZERO_EN defined: address 0 returns 0.
REQ-027 No-write scenario: after REQ-026, hold rst_wen_onehot = 0 and cdb_wdata = 0xDEADBEEF for 4 cycles.
- Required: all registers are unchanged; register 7 still reads 8.
REQ-028 Write-through scenario: set dispatch_rsaddr = 5, rst_wen_onehot = 1<<5, cdb_wdata = 0x12345678 in the same cycle.
- Required: dispatch_rsdata = 0x12345678 before the clock edge, and the value persists after it.
REQ-029 Multi-hot scenario: drive rst_wen_onehot = 0x0000_0300 with cdb_wdata = 0xA5A5A5A5.
- Required: registers 8 and 9 both read 0xA5A5A5A5; register 10 is unchanged.
REQ-030 Asynchronous reset scenario: assert reset = 0 mid-cycle after REQ-026.
- Required: all three ports read 0 immediately; after release, all registers read 0 until rewritten.
